// File: rtl/tt_sweep_if.sv
// -----------------------------------------------------------------------------
// tt_sweep_if
// Truth-table word stream from the sweep engine to the result collector.
//   word_data  : truth-table word (most-significant word of the table first)
//   word_valid : word_data holds a word
//   word_ready : collector can take the word
//   word_last  : marks the final word of a sweep
// Handshake: a word transfers on a rising clock edge where word_valid and
// word_ready are both high. Once word_valid rises, it stays high and
// word_data/word_last stay stable until that transfer happens. word_ready
// may change freely and is allowed to depend on word_valid.
// -----------------------------------------------------------------------------
interface tt_sweep_if #(
   parameter int WORD_W = 32
);
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;
   logic              word_last;

   modport master (
      output word_data,
      output word_valid,
      output word_last,
      input  word_ready
   );

   modport slave (
      input  word_data,
      input  word_valid,
      input  word_last,
      output word_ready
   );
endinterface

// File: rtl/tt_sweep.sv
// -----------------------------------------------------------------------------
// tt_sweep
// Truth-table capture engine for a 7-input, 1-output combinational block.
// After a start pulse, it drives minterms 127 down to 0 on x and samples
// f_in at the end of each cycle. It packs the samples into 32-bit words and
// emits them most-significant word first, so the stream reads as the
// function's hex classification name.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : sweep request, looked at only while idle
//   x          : minterm driven to the function under test (registered)
//   f_in       : function output, combinational from x
//   busy       : sweep in progress
//   done       : one-cycle pulse after the final word is accepted
//   state_o    : current FSM state, for observation
//   word_if    : word stream (data/valid/ready/last)
// -----------------------------------------------------------------------------
module tt_sweep #(
   parameter int N_IN   = 7,
   parameter int WORD_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] x,
   input  logic            f_in,
   output logic            busy,
   output logic            done,
   output logic [1:0]      state_o,
   tt_sweep_if.master      word_if
);
   localparam int NWORDS = (2 ** N_IN) / WORD_W;
   localparam int BCW    = $clog2(WORD_W);
   localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [WORD_W-2:0] cap_q, cap_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]    word_cnt_q, word_cnt_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic accept;
   logic word_end;
   logic stall;

   assign accept   = valid_q && word_if.word_ready;
   assign word_end = (bit_cnt_q == BCW'(WORD_W - 1));
   // The sample that completes a word needs the output register; it waits
   // while the previous word is still unaccepted. Other samples never wait.
   assign stall    = word_end && valid_q && !word_if.word_ready;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cap_d      = cap_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      data_d     = data_q;
      valid_d    = valid_q;
      last_d     = last_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      if (accept) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SWEEP;
               idx_d      = '1;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               busy_d     = 1'b1;
            end
         end
         SWEEP: begin
            if (!stall) begin
               cap_d     = {cap_q[WORD_W-3:0], f_in};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (word_end) begin
                  // Loading a new word overrides a same-cycle acceptance clear.
                  data_d     = {cap_q, f_in};
                  valid_d    = 1'b1;
                  last_d     = (word_cnt_q == WCW'(NWORDS - 1));
                  word_cnt_d = word_cnt_q + 1'b1;
               end
               if (idx_q == '0) begin
                  state_d = FLUSH;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
         FLUSH: begin
            // Only the final word can be pending here; earlier words had to
            // be accepted before the following word could complete.
            if (accept && last_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cap_q      <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cap_q      <= cap_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign x                  = idx_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign state_o            = state_q;
   assign word_if.word_data  = data_q;
   assign word_if.word_valid = valid_q;
   assign word_if.word_last  = last_q;
endmodule

// File: tb/tb_tt_sweep.sv
// -----------------------------------------------------------------------------
// tb_tt_sweep
// Directed bench for tt_sweep. The function under test is a 128-entry table
// indexed by x. Cycle 0 is the cycle in which start is high.
// -----------------------------------------------------------------------------
module tb_tt_sweep;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [6:0] x;
   logic       f_in;
   logic       busy;
   logic       done;
   logic [1:0] state_o;

   tt_sweep_if #(.WORD_W(32)) wif ();

   tt_sweep dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .x       (x),
      .f_in    (f_in),
      .busy    (busy),
      .done    (done),
      .state_o (state_o),
      .word_if (wif.master)
   );

   always #5 clk = ~clk;

   logic [127:0] tt_ref = '0;
   assign f_in = tt_ref[x];

   int n_vec = 0;
   int n_err = 0;

   // ready pattern: 0 = always high, 1 = low in cycles rdy_lo..rdy_hi, 2 = random
   int rdy_mode = 0;
   int rdy_lo = 0;
   int rdy_hi = -1;

   // collected sweep results
   logic [31:0] got_w [0:7];
   logic        got_last [0:7];
   int          n_words;
   int          n_done;
   int          done_cyc;
   int          stable_err;
   logic [6:0]  x_c1;
   logic        busy_c1;
   logic [6:0]  x_probe;
   logic        busy_at_done;

   task automatic set_ready(input int cyc);
      case (rdy_mode)
         1:       wif.word_ready = !(cyc >= rdy_lo && cyc <= rdy_hi);
         2:       wif.word_ready = 1'($urandom_range(0, 1));
         default: wif.word_ready = 1'b1;
      endcase
   endtask

   // Runs one sweep; extra start pulses in cycles s1/s2, x recorded at probe.
   task automatic do_sweep(input int s1, input int s2, input int probe);
      logic        pend;
      logic [31:0] pend_data;
      n_words = 0; n_done = 0; done_cyc = -1; stable_err = 0;
      pend = 1'b0; pend_data = '0; x_probe = '0; busy_at_done = 1'b1;
      for (int i = 0; i < 8; i++) begin
         got_w[i] = '0;
         got_last[i] = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b1;
      set_ready(0);
      @(negedge clk);
      for (int cyc = 1; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == s1) || (cyc == s2);
         set_ready(cyc);
         @(negedge clk);
         if (cyc == 1) begin
            x_c1 = x;
            busy_c1 = busy;
         end
         if (cyc == probe) x_probe = x;
         if (pend && (wif.word_valid !== 1'b1 || wif.word_data !== pend_data)) stable_err++;
         pend = wif.word_valid && !wif.word_ready;
         pend_data = wif.word_data;
         if (wif.word_valid && wif.word_ready) begin
            if (n_words < 8) begin
               got_w[n_words] = wif.word_data;
               got_last[n_words] = wif.word_last;
            end
            n_words++;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               busy_at_done = busy;
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
      end
      start = 1'b0;
      wif.word_ready = 1'b1;
   endtask

   task automatic test_reset;
      wif.word_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({x, busy, done, wif.word_valid, wif.word_last, wif.word_data, state_o} !== '0) begin
         n_err++;
         $display("FAIL reset_hold: x=%0d busy=%b done=%b valid=%b last=%b data=%h state=%0d required all zero",
                  x, busy, done, wif.word_valid, wif.word_last, wif.word_data, state_o);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({x, busy, done, wif.word_valid, wif.word_last, wif.word_data, state_o} !== '0) begin
         n_err++;
         $display("FAIL reset_idle: x=%0d busy=%b valid=%b data=%h state=%0d required all zero",
                  x, busy, wif.word_valid, wif.word_data, state_o);
      end
   endtask

   task automatic test_patterns;
      logic [127:0] tabs [0:2];
      logic [31:0]  exp_w [0:2][0:3];
      tabs[0] = {64'hffff_ffff_ffff_ffff, 64'h0};   // f = x6
      tabs[1] = {4{32'haaaa_aaaa}};                 // f = x0
      tabs[2] = {1'b1, 127'b0};                     // f = AND of all inputs
      exp_w[0] = '{32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0000};
      exp_w[1] = '{32'haaaa_aaaa, 32'haaaa_aaaa, 32'haaaa_aaaa, 32'haaaa_aaaa};
      exp_w[2] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      for (int p = 0; p < 3; p++) begin
         tt_ref = tabs[p];
         rdy_mode = 0;
         do_sweep(-1, -1, -1);
         n_vec++;
         if (x_c1 !== 7'd127 || busy_c1 !== 1'b1) begin
            n_err++;
            $display("FAIL pat%0d_cycle1: x=%0d busy=%b required x=127 busy=1", p, x_c1, busy_c1);
         end
         n_vec++;
         if (n_words !== 4) begin
            n_err++;
            $display("FAIL pat%0d_count: words=%0d required 4", p, n_words);
         end
         for (int w = 0; w < 4; w++) begin
            n_vec++;
            if (got_w[w] !== exp_w[p][w] || got_last[w] !== (w == 3)) begin
               n_err++;
               $display("FAIL pat%0d_word%0d: data=%h last=%b required data=%h last=%b",
                        p, w, got_w[w], got_last[w], exp_w[p][w], (w == 3));
            end
         end
         n_vec++;
         if (done_cyc !== 130 || n_done !== 1 || busy_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL pat%0d_done: cycle=%0d pulses=%0d busy=%b required cycle=130 pulses=1 busy=0",
                     p, done_cyc, n_done, busy_at_done);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_w [0:3];
      exp_w = '{32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0000};
      tt_ref = {64'hffff_ffff_ffff_ffff, 64'h0};
      // first word held unaccepted long enough that the second word's final
      // sample (minterm 64, cycle 64) waits through cycles 64..73
      rdy_mode = 1; rdy_lo = 33; rdy_hi = 73;
      do_sweep(-1, -1, 70);
      rdy_mode = 0;
      n_vec++;
      if (stable_err !== 0) begin
        n_err++;
        $display("FAIL bp_stable: changes_while_pending=%0d required 0", stable_err);
      end
      n_vec++;
      if (x_probe !== 7'd64) begin
         n_err++;
         $display("FAIL bp_x_frozen: x=%0d required 64", x_probe);
      end
      n_vec++;
      if (n_words !== 4) begin
         n_err++;
         $display("FAIL bp_count: words=%0d required 4", n_words);
      end
      for (int w = 0; w < 4; w++) begin
         n_vec++;
         if (got_w[w] !== exp_w[w] || got_last[w] !== (w == 3)) begin
            n_err++;
            $display("FAIL bp_word%0d: data=%h last=%b required data=%h last=%b",
                     w, got_w[w], got_last[w], exp_w[w], (w == 3));
         end
      end
      n_vec++;
      if (done_cyc !== 140 || n_done !== 1) begin
         n_err++;
         $display("FAIL bp_done: cycle=%0d pulses=%0d required cycle=140 pulses=1", done_cyc, n_done);
      end
   endtask

   task automatic test_random;
      logic [127:0] exp_tt;
      logic [127:0] got_tt;
      for (int r = 0; r < 3; r++) begin
         tt_ref = {$urandom, $urandom, $urandom, $urandom};
         exp_tt = tt_ref;
         rdy_mode = 2;
         do_sweep(-1, -1, -1);
         rdy_mode = 0;
         got_tt = {got_w[0], got_w[1], got_w[2], got_w[3]};
         n_vec++;
         if (n_words !== 4 || got_tt !== exp_tt) begin
            n_err++;
            $display("FAIL rand%0d_table: words=%0d table=%h required words=4 table=%h",
                     r, n_words, got_tt, exp_tt);
         end
         n_vec++;
         if ({got_last[0], got_last[1], got_last[2], got_last[3]} !== 4'b0001 || n_done !== 1) begin
            n_err++;
            $display("FAIL rand%0d_last: last=%b%b%b%b pulses=%0d required 0001 pulses=1",
                     r, got_last[0], got_last[1], got_last[2], got_last[3], n_done);
         end
      end
   endtask

   task automatic test_reset_mid;
      int stray;
      tt_ref = {4{32'haaaa_aaaa}};
      wif.word_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({x, busy, done, wif.word_valid, wif.word_last, wif.word_data, state_o} !== '0) begin
         n_err++;
         $display("FAIL rst_mid: x=%0d busy=%b done=%b valid=%b last=%b data=%h state=%0d required all zero",
                  x, busy, done, wif.word_valid, wif.word_last, wif.word_data, state_o);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      stray = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         @(negedge clk);
         if (wif.word_valid || done || busy) stray++;
      end
      n_vec++;
      if (stray !== 0) begin
         n_err++;
         $display("FAIL rst_quiet: active_cycles=%0d required 0", stray);
      end
      do_sweep(-1, -1, -1);
      n_vec++;
      if (n_words !== 4 || got_w[0] !== 32'haaaa_aaaa || got_w[3] !== 32'haaaa_aaaa ||
          got_last[3] !== 1'b1 || done_cyc !== 130) begin
         n_err++;
         $display("FAIL rst_restart: words=%0d w0=%h w3=%h last3=%b done=%0d required 4 aaaaaaaa aaaaaaaa 1 130",
                  n_words, got_w[0], got_w[3], got_last[3], done_cyc);
      end
   endtask

   task automatic test_ignore_start;
      tt_ref = {64'hffff_ffff_ffff_ffff, 64'h0};
      rdy_mode = 0;
      do_sweep(5, 70, -1);
      n_vec++;
      if (n_words !== 4 || n_done !== 1 || done_cyc !== 130) begin
         n_err++;
         $display("FAIL ign_start: words=%0d pulses=%0d done=%0d required 4 1 130",
                  n_words, n_done, done_cyc);
      end
      n_vec++;
      if (got_w[0] !== 32'hffff_ffff || got_w[1] !== 32'hffff_ffff ||
          got_w[2] !== 32'h0 || got_w[3] !== 32'h0) begin
         n_err++;
         $display("FAIL ign_stream: %h %h %h %h required ffffffff ffffffff 00000000 00000000",
                  got_w[0], got_w[1], got_w[2], got_w[3]);
      end
      n_vec++;
      if (state_o !== 2'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL ign_idle: state=%0d busy=%b required 0 0", state_o, busy);
      end
   endtask

   initial begin
      wif.word_ready = 1'b1;
      test_reset();
      test_patterns();
      test_backpressure();
      test_random();
      test_reset_mid();
      test_ignore_start();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
